mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 23 ++
 rtl/mem_io_responder_fifo.sv | 62 ++++++
 rtl/mem_io_responder.sv | 159 +++++++++++++++
 tb/tb_mem_io_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder.
// Holds the I/O register map, the default RAM address width, the read-data
// source selector and a byte-extraction helper used for counter snapshots.
package mem_io_responder_pkg;

   localparam int          RAM_ADDR_W_DEF = 17;

   localparam logic [1:0]  IO_SPACE       = 2'b11;
   localparam logic [17:0] IO_DATA_ADDR   = 18'h30000;
   localparam logic [17:0] IO_CTRL_ADDR   = 18'h30004;

   typedef enum logic {
      RD_SRC_IO  = 1'b0,
      RD_SRC_RAM = 1'b1
   } rd_src_t;

   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
      logic [31:0] shifted;
      shifted = word >> {sel, 3'b000};
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// byte_fifo: synchronous single-clock byte FIFO, power-of-two depth.
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset (empties FIFO)
//   push, push_data    write request; ignored while full
//   pop                read request; ignored while empty
//   head               byte at the head of the FIFO (valid while !empty)
//   full, empty, count occupancy status
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU-side responder with byte RAM, UART RX/TX FIFOs,
// a free-running cycle counter and a sticky program-stop flag.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   cpu_a, cpu_dout, cpu_wr   CPU address / write data / write strobe
//   cpu_din                   read data, valid the cycle after the read
//   cpu_rdy                   low freezes the CPU (read of empty RX data reg)
//   io_buffer_full            TX FIFO within two entries of full
//   rx_valid/rx_data/rx_ready UART receive byte stream (into RX FIFO)
//   tx_valid/tx_data/tx_ready UART transmit byte stream (from TX FIFO)
//   prog_done                 set by a write to the control register
module mem_io_responder
   import mem_io_responder_pkg::*;
#(
   parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_din,
   output logic        cpu_rdy,
   output logic        io_buffer_full,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        prog_done
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [17:0]           addr;
   logic [RAM_ADDR_W-1:0] ram_idx;
   logic                  is_io;
   logic                  is_data;
   logic                  is_ctrl;
   logic                  is_snap_hi;
   logic                  act;
   logic                  unused_addr_hi;

   logic                  rx_pop;
   logic                  rx_empty;
   logic                  rx_full;
   logic [7:0]            rx_head;
   logic [CNT_W-1:0]      rx_level_unused;

   logic                  tx_push;
   logic [7:0]            tx_push_data;
   logic                  tx_empty;
   logic                  tx_full_unused;
   logic [CNT_W-1:0]      tx_count;

   logic [7:0]            ram [2**RAM_ADDR_W];
   logic [7:0]            ram_q;
   logic [7:0]            io_q;
   rd_src_t               rd_src;
   logic [31:0]           cycle_cnt;
   logic [31:0]           snap;

   assign addr           = cpu_a[17:0];
   assign ram_idx        = cpu_a[RAM_ADDR_W-1:0];
   assign unused_addr_hi = ^cpu_a[31:18];

   assign is_io      = (addr[17:16] == IO_SPACE);
   assign is_data    = (addr == IO_DATA_ADDR);
   assign is_ctrl    = (addr == IO_CTRL_ADDR);
   assign is_snap_hi = (addr[17:2] == IO_CTRL_ADDR[17:2]) && (addr[1:0] != 2'b00);

   // Reading the RX data register with nothing buffered freezes the CPU
   // until a byte lands; the pop then happens in that same cycle.
   assign cpu_rdy = !(!cpu_wr && is_data && rx_empty);
   assign act     = cpu_rdy && !rst_in;

   assign rx_pop       = act && !cpu_wr && is_data;
   assign rx_ready     = !rx_full;
   assign tx_push      = act && cpu_wr && ((is_data && (cpu_dout != 8'h00)) || is_ctrl);
   assign tx_push_data = is_ctrl ? 8'h00 : cpu_dout;
   assign tx_valid     = !tx_empty;

   assign io_buffer_full = (tx_count >= CNT_W'(FIFO_DEPTH - 2));

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (rx_valid && rx_ready),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_level_unused)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_valid && tx_ready),
      .head      (tx_data),
      .full      (tx_full_unused),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   // RAM is left without reset so it can map onto block memory.
   always_ff @(posedge clk_in) begin
      if (act && !is_io) begin
         if (cpu_wr) begin
            ram[ram_idx] <= cpu_dout;
         end else begin
            ram_q <= ram[ram_idx];
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cycle_cnt <= '0;
         snap      <= '0;
         prog_done <= 1'b0;
         io_q      <= 8'h00;
         rd_src    <= RD_SRC_IO;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (act) begin
            if (cpu_wr) begin
               if (is_ctrl) begin
                  prog_done <= 1'b1;
               end
            end else if (!is_io) begin
               rd_src <= RD_SRC_RAM;
            end else begin
               rd_src <= RD_SRC_IO;
               if (is_data) begin
                  io_q <= rx_head;
               end else if (is_ctrl) begin
                  snap <= cycle_cnt;
                  io_q <= cycle_cnt[7:0];
               end else if (is_snap_hi) begin
                  // upper bytes come from the last snapshot so a multi-byte
                  // read sees one coherent counter value
                  io_q <= word_byte(snap, addr[1:0]);
               end else begin
                  io_q <= 8'h00;
               end
            end
         end
      end
   end

   assign cpu_din = (rd_src == RD_SRC_RAM) ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

   localparam int DEPTH = 16;

   logic        clk_in;
   logic        rst_in;
   logic [31:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic        cpu_rdy;
   logic        io_buffer_full;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        prog_done;

   mem_io_responder #(.RAM_ADDR_W(17), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .cpu_a          (cpu_a),
      .cpu_dout       (cpu_dout),
      .cpu_wr         (cpu_wr),
      .cpu_din        (cpu_din),
      .cpu_rdy        (cpu_rdy),
      .io_buffer_full (io_buffer_full),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready),
      .prog_done      (prog_done)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // reference model state
   logic [7:0]  m_ram [int];
   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   logic [31:0] m_cnt;
   logic [31:0] m_snap;
   logic        m_pd;
   logic [7:0]  m_din;
   logic        m_din_known;
   logic [7:0]  dut_tx_log[$];

   int n_chk = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1: drive inputs, check combinational outputs mid-cycle,
   // take the edge, advance the model, check registered outputs.
   task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d,
                       input logic rxv, input logic [7:0] rxd, input logic txr,
                       input logic rst, output logic rdy_o);
      logic [17:0] a18;
      logic        e_rdy;
      int          rx_n;
      int          tx_n;
      cpu_wr = wr; cpu_a = a; cpu_dout = d;
      rx_valid = rxv; rx_data = rxd; tx_ready = txr; rst_in = rst;
      a18   = a[17:0];
      rx_n  = rxq.size();
      tx_n  = txq.size();
      e_rdy = !(!wr && a18 == 18'h30000 && rx_n == 0);
      rdy_o = e_rdy;
      #4;
      if (!rst) begin
         check_val("cpu_rdy", cpu_rdy, e_rdy);
         check_val("rx_ready", rx_ready, rx_n < DEPTH);
         check_val("tx_valid", tx_valid, tx_n > 0);
         if (tx_n > 0) check_val("tx_data", tx_data, txq[0]);
         check_val("io_buffer_full", io_buffer_full, tx_n >= DEPTH - 2);
      end
      if (tx_valid && tx_ready) dut_tx_log.push_back(tx_data);
      @(posedge clk_in);
      #1;
      if (rst) begin
         rxq.delete(); txq.delete();
         m_cnt = 0; m_snap = 0; m_pd = 0; m_din = 0; m_din_known = 1;
      end else begin
         if (tx_n > 0 && txr) void'(txq.pop_front());
         if (e_rdy) begin
            if (wr) begin
               m_din_known = 0;
               if (a18[17:16] == 2'b11) begin
                  if (a18 == 18'h30000 && d != 8'h00 && tx_n < DEPTH) txq.push_back(d);
                  else if (a18 == 18'h30004) begin
                     if (tx_n < DEPTH) txq.push_back(8'h00);
                     m_pd = 1;
                  end
               end else begin
                  m_ram[int'(a[16:0])] = d;
               end
            end else if (a18[17:16] == 2'b11) begin
               m_din_known = 1;
               case (a18)
                  18'h30000: m_din = rxq.pop_front();
                  18'h30004: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                  18'h30005, 18'h30006, 18'h30007:
                     m_din = 8'(m_snap >> (8 * int'(a18[1:0])));
                  default:   m_din = 8'h00;
               endcase
            end else if (m_ram.exists(int'(a[16:0]))) begin
               m_din = m_ram[int'(a[16:0])];
               m_din_known = 1;
            end else begin
               m_din_known = 0;
            end
         end
         if (rxv && rx_n < DEPTH) rxq.push_back(rxd);
         m_cnt = m_cnt + 1;
      end
      if (m_din_known) check_val("cpu_din", cpu_din, m_din);
      check_val("prog_done", prog_done, m_pd);
   endtask

   task automatic do_reset();
      logic r;
      step(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, r);
   endtask

   task automatic idle(input int n, input logic txr);
      logic r;
      for (int i = 0; i < n; i++) step(1'b0, 32'h30008, 8'h00, 1'b0, 8'h00, txr, 1'b0, r);
   endtask

   logic        rdy;
   logic        w;
   logic [31:0] a;
   logic [7:0]  d;
   logic [31:0] io_tab [7] = '{32'h30000, 32'h30004, 32'h30005, 32'h30006,
                               32'h30007, 32'h30008, 32'h3FFFF};

   initial begin
      cpu_wr = 0; cpu_a = 0; cpu_dout = 0; rx_valid = 0; rx_data = 0; tx_ready = 0; rst_in = 1;
      m_din_known = 0;
      @(posedge clk_in);
      #1;
      do_reset();
      check_val("rst_din", cpu_din, 8'h00);
      check_val("rst_pd", prog_done, 1'b0);
      check_val("rst_tx_valid", tx_valid, 1'b0);
      check_val("rst_rx_ready", rx_ready, 1'b1);
      check_val("rst_cpu_rdy", cpu_rdy, 1'b1);

      // RAM write then read, latency 1
      step(1'b1, 32'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      step(1'b0, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      check_val("ram_rd", cpu_din, 8'hA5);

      // RX read stalls while empty, resumes when a byte arrives
      for (int i = 0; i < 5; i++) step(1'b0, 32'h30000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      step(1'b0, 32'h30000, 8'h00, 1'b1, 8'h41, 1'b0, 1'b0, rdy);
      step(1'b0, 32'h30000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      check_val("rx_rd", cpu_din, 8'h41);

      // TX: zero byte suppressed
      dut_tx_log.delete();
      step(1'b1, 32'h30000, 8'h48, 1'b0, 8'h00, 1'b1, 1'b0, rdy);
      step(1'b1, 32'h30000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, rdy);
      step(1'b1, 32'h30000, 8'h69, 1'b0, 8'h00, 1'b1, 1'b0, rdy);
      idle(4, 1'b1);
      check_val("tx_stream_n", dut_tx_log.size(), 2);
      if (dut_tx_log.size() >= 2) begin
         check_val("tx_stream_0", dut_tx_log[0], 8'h48);
         check_val("tx_stream_1", dut_tx_log[1], 8'h69);
      end

      // TX fill: near-full from 14, 17th write dropped
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         step(1'b1, 32'h30000, 8'(16 + k), 1'b0, 8'h00, 1'b0, 1'b0, rdy);
         check_val("fill_near_full", io_buffer_full, k >= 14);
      end
      dut_tx_log.delete();
      idle(20, 1'b1);
      check_val("fill_drained_n", dut_tx_log.size(), 16);
      if (dut_tx_log.size() == 16) check_val("fill_last", dut_tx_log[15], 8'h20);

      // counter snapshot
      do_reset();
      for (int i = 0; i < 1000 && m_cnt != 32'h123; i++) idle(1, 1'b0);
      step(1'b0, 32'h30004, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      check_val("snap_b0", cpu_din, 8'h23);
      idle(300, 1'b0);
      step(1'b0, 32'h30005, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      check_val("snap_b1", cpu_din, 8'h01);

      // prog_done then reset mid-stream
      step(1'b1, 32'h30004, 8'h77, 1'b1, 8'h11, 1'b0, 1'b0, rdy);
      check_val("pd_set", prog_done, 1'b1);
      step(1'b1, 32'h30000, 8'h55, 1'b1, 8'h22, 1'b0, 1'b0, rdy);
      step(1'b0, 32'h30000, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, rdy);
      step(1'b0, 32'h0, 8'h00, 1'b1, 8'h44, 1'b1, 1'b1, rdy);
      rxq.delete(); txq.delete();
      check_val("rst2_pd", prog_done, 1'b0);
      check_val("rst2_tx_valid", tx_valid, 1'b0);
      check_val("rst2_rx_ready", rx_ready, 1'b1);
      check_val("rst2_cpu_din", cpu_din, 8'h00);
      step(1'b0, 32'h10, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, rdy);
      check_val("ram_keep", cpu_din, 8'hA5);

      // randomized traffic against the model
      rdy = 1'b1;
      w = 1'b0; a = 32'h0; d = 8'h00;
      for (int i = 0; i < 1500; i++) begin
         if (rdy) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 4)
               a = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
            else
               a = ($urandom & 32'hFFFC_0000) | io_tab[$urandom_range(0, 6)];
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         end
         step(w, a, d, $urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, rdy);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
